// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor family.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int MIN_WIDTH = 2;

    // Bit count needed to index WIDTH serial steps.
    function automatic int cnt_width(input int width);
        return (width <= MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sub_01bit_full.sv
// Combinational 1-bit full subtractor: a - b - bor.
module sub_01bit_full (
    input  logic i_num_a,
    input  logic i_num_b,
    input  logic i_bor,
    output logic o_res,
    output logic o_bor
);

    assign o_res = i_num_a ^ i_num_b ^ i_bor;
    assign o_bor = (~i_num_a & i_num_b) | (~i_num_a & i_bor) | (i_num_b & i_bor);

endmodule

// File: rtl/sub_nbit_serial.sv
// Bit-serial WIDTH-bit subtractor (A - B - borrow), LSB first, with valid/ready on both sides.
module sub_nbit_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_num_a,
    input  logic [WIDTH-1:0] i_num_b,
    input  logic             i_bor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_bor,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             bor;
    logic             bor_n;
    logic             diff;
    logic             a_msb;
    logic             b_msb;

    sub_01bit_full u_cell (
        .i_num_a (a_sh[0]),
        .i_num_b (b_sh[0]),
        .i_bor   (bor),
        .o_res   (diff),
        .o_bor   (bor_n)
    );

    // Result bits enter at the top so the LSB lands in bit 0 after WIDTH shifts.
    assign res_next = {diff, r_sh[WIDTH-1:1]};

    assign o_ready = i_rst_n && (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            o_res  <= '0;
            o_bor  <= 1'b0;
            o_ovf  <= 1'b0;
            o_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sh  <= i_num_a;
                        b_sh  <= i_num_b;
                        bor   <= i_bor;
                        cnt   <= '0;
                        a_msb <= i_num_a[WIDTH-1];
                        b_msb <= i_num_b[WIDTH-1];
                        state <= CALC;
                    end
                end
                CALC: begin
                    r_sh <= res_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bor  <= bor_n;
                    // Counter holds on the final step rather than wrapping.
                    if (cnt == CNT_LAST) begin
                        o_res  <= res_next;
                        o_bor  <= bor_n;
                        o_ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        o_zero <= ~|res_next;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Randomised self-checking bench for sub_nbit_serial at WIDTH=8 with an arithmetic reference model.
module tb_sub_nbit_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready_dut;
    logic [W-1:0] num_a;
    logic [W-1:0] num_b;
    logic         bor_in;
    logic         res_valid;
    logic         down_ready;
    logic [W-1:0] res;
    logic         bor_out;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    sub_nbit_serial #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready_dut),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .i_bor   (bor_in),
        .o_valid (res_valid),
        .i_ready (down_ready),
        .o_res   (res),
        .o_bor   (bor_out),
        .o_ovf   (ovf),
        .o_zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for its result, compare against plain arithmetic,
    // hold i_ready low for 'hold' DONE cycles, then release it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input int hold, input bit chk_lat, input bit poke);
        int          lat;
        int          wait_cyc;
        int          sa;
        int          sb;
        int          sdiff;
        logic [W:0]  full;
        logic [W-1:0] exp_res;
        logic        exp_bor;
        logic        exp_ovf;
        logic [W-1:0] held;

        full    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        exp_res = full[W-1:0];
        exp_bor = full[W];
        sa      = int'($signed(a));
        sb      = int'($signed(b));
        sdiff   = sa - sb - int'(bi);
        exp_ovf = (sdiff < -(1 << (W-1))) || (sdiff > (1 << (W-1)) - 1);

        wait_cyc = 0;
        while (!out_ready_dut && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        if (!out_ready_dut) check("ready_timeout", 32'(out_ready_dut), 32'd1);

        num_a      = a;
        num_b      = b;
        bor_in     = bi;
        in_valid   = 1'b1;
        down_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        num_a    = W'($urandom);
        num_b    = W'($urandom);
        bor_in   = 1'($urandom);
        check("busy_not_ready", 32'(out_ready_dut), 32'd0);

        lat = 0;
        while (!res_valid && lat < 40) begin
            if (poke && lat == 3) begin
                in_valid = 1'b1;
                num_a    = ~a;
                num_b    = a;
                bor_in   = ~bi;
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        if (!res_valid) check("valid_timeout", 32'(res_valid), 32'd1);
        if (chk_lat) check("latency", 32'(lat), 32'(W));

        check("res",  32'(res),     32'(exp_res));
        check("bor",  32'(bor_out), 32'(exp_bor));
        check("ovf",  32'(ovf),     32'(exp_ovf));
        check("zero", 32'(zero),    32'(exp_res == '0));

        held = res;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_res",   32'(res),       32'(held));
        end
        down_ready = 1'b1;
        step();
        check("valid_drop", 32'(res_valid),     32'd0);
        check("ready_back", 32'(out_ready_dut), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        num_a      = '0;
        num_b      = '0;
        bor_in     = 1'b0;
        down_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(res_valid),     32'd0);
        check("rst_ready", 32'(out_ready_dut), 32'd0);
        check("rst_res",   32'(res),           32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ready", 32'(out_ready_dut), 32'd1);

        // Directed cases, including borrow-in and signed-overflow boundaries.
        do_op(8'h05, 8'h03, 1'b0, 0, 1'b1, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 0, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 0, 1'b1, 1'b0);
        do_op(8'h10, 8'h0F, 1'b1, 0, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 0, 1'b1, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 0, 1'b1, 1'b0);
        do_op(8'hA5, 8'hA5, 1'b1, 0, 1'b1, 1'b0);
        do_op(8'h3C, 8'h21, 1'b0, 3, 1'b1, 1'b1);

        // Reset in the middle of CALC, with i_valid asserted throughout reset.
        num_a    = 8'h55;
        num_b    = 8'h11;
        bor_in   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        step();
        check("midrst_valid", 32'(res_valid),     32'd0);
        check("midrst_res",   32'(res),           32'd0);
        check("midrst_bor",   32'(bor_out),       32'd0);
        check("midrst_ready", 32'(out_ready_dut), 32'd0);
        step();
        check("midrst_ready2", 32'(out_ready_dut), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        check("postrst_ready", 32'(out_ready_dut), 32'd1);
        check("postrst_valid", 32'(res_valid),     32'd0);
        do_op(8'hC8, 8'h37, 1'b1, 1, 1'b1, 1'b0);

        // Back-to-back random traffic with random downstream stalls.
        for (int t = 0; t < 1000; t++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'b1, (t % 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_nbit_serial.md
Name: sub_nbit_serial

Overview:
Bit-serial N-bit subtractor computing A - B - borrow_in, one bit per clock, LSB first. It is the inverse-operation counterpart to the add family: the datapath cell is a 1-bit full subtractor, iterated over WIDTH cycles. Valid/ready handshakes on input and output let it sit between pipeline stages in the calc datapath where area matters more than latency.

Parameters:
WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.

Ports:
i_clk     input   1      clock; all state updates on its rising edge
i_rst_n   input   1      reset, synchronous, active-low
i_valid   input   1      operands valid
o_ready   output  1      block can accept operands
i_num_a   input   WIDTH  minuend A
i_num_b   input   WIDTH  subtrahend B
i_bor     input   1      borrow in
o_valid   output  1      result valid
i_ready   input   1      downstream accepts result
o_res     output  WIDTH  A - B - i_bor mod 2^WIDTH
o_bor     output  1      unsigned borrow out; 1 iff A < B + i_bor
o_ovf     output  1      signed overflow (two's complement)
o_zero    output  1      1 iff o_res == 0

Behaviour:
- One clock, i_clk. Reset is synchronous, active-low on i_rst_n.
- While i_rst_n is low at a rising edge: state <= IDLE; shift registers, borrow flop, counter, o_res, o_bor, o_ovf and o_zero <= 0.
- o_valid = 0 whenever state != DONE. o_ready = 0 while i_rst_n is low.
- FSM states: IDLE, CALC, DONE.
  - IDLE: o_ready = 1, o_valid = 0.
    - On i_valid & o_ready: latch A into a_sh and B into b_sh, borrow flop <= i_bor, cnt <= 0.
    - Capture a_msb = A[WIDTH-1] and b_msb = B[WIDTH-1].
    - Go to CALC.
  - CALC: o_ready = 0, and i_valid is ignored.
    - Each cycle, the sub-cell computes d = a_sh[0] ^ b_sh[0] ^ bor and bor_n = (~a & b) | (~a & bor) | (b & bor).
    - r_sh <= {d, r_sh[WIDTH-1:1]}. a_sh and b_sh shift right by 1. bor <= bor_n. cnt++.
    - When cnt == WIDTH-1, go to DONE after this cycle.
    - CALC lasts exactly WIDTH cycles.
  - DONE: o_valid = 1, o_ready = 0.
    - o_res = r_sh and o_bor = final borrow.
    - o_ovf = (a_msb != b_msb) & (o_res[WIDTH-1] != a_msb).
    - o_zero = ~|o_res.
    - Outputs stay stable while i_ready is low.
    - On i_ready, go to IDLE.
- Latency: if operands are accepted at edge E0, o_valid is high after edge E0+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH CALC cycles, one DONE cycle with i_ready high.
  - There is no overlap of accept and DONE.
- o_res, o_bor, o_ovf and o_zero are registered or derived from registers only. No combinational path from i_num_* to outputs.
- Boundaries:
  - i_ready held high on entry to DONE: o_valid pulses for exactly 1 cycle.
  - Input operands may change after acceptance without affecting the result.
  - Reset mid-CALC or mid-DONE: next cycle is IDLE with all outputs 0, and the pending result is discarded.
  - i_valid high during reset: not accepted.
  - i_bor = 1 with A = B gives o_res = all-ones and o_bor = 1.
  - cnt width is $clog2(WIDTH). The counter does not wrap during CALC.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_e.
  - Localparam helper for counter width.
- Sub-module sub_01bit_full with ports i_num_a, i_num_b, i_bor, o_res, o_bor. It is a purely combinational 1-bit full subtractor using the equations above, instantiated once in the serial datapath.

Test Plan (WIDTH=8):
- A=0x05, B=0x03, bor=0 -> o_res=0x02, o_bor=0, o_ovf=0, o_zero=0; o_valid rises exactly 8 cycles after the accept edge.
- A=0x03, B=0x05, bor=0 -> o_res=0xFE, o_bor=1, o_ovf=0. Also A=0x80, B=0x01 -> o_res=0x7F, o_ovf=1, o_bor=0.
- A=0x10, B=0x0F, bor=1 -> o_res=0x00, o_zero=1, o_bor=0. Also A=0x00, B=0x00, bor=1 -> o_res=0xFF, o_bor=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE -> o_valid and o_res stable throughout; one cycle after i_ready=1, o_ready=1. Pulse i_valid with new operands during CALC -> ignored, and the first result is unchanged.
- Reset: drive i_rst_n=0 at CALC cycle 4 -> next cycle state is IDLE, o_valid=0, o_res=0, o_ready=0 while reset is held and 1 after release. A new operation then completes correctly.
- Random: 1000 back-to-back transactions with random A, B, bor and random i_ready -> each result matches the scoreboard (A-B-bor) mod 256, with borrow and overflow checked.
